memory_controller: RTL

//  Memory-mapped bus target that consumes the datapath's Address/WriteData/MemWrite_Enable and returns ReadData.

---
 rtl/memory_controller.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/memory_controller.sv
// memory_controller: memory-mapped bus target for a single-cycle CPU.
// 0x00-0xEF is data RAM. 0xF0-0xFF holds the peripherals: GPIO, an 8-bit
// timer and a UART transmitter fed by a small TX FIFO.
// Reads are combinational from Address and have no side effects.
// Writes commit on the rising clk edge while MemWrite_Enable is high.
//
// Handshake: there is no valid/ready pair. MemWrite_Enable is the only
// request. A write is always accepted on the edge where it is high. The one
// exception is a UART_TX write while the FIFO is full and nothing pops on the
// same edge: that byte is dropped and the sticky ovf flag is raised.
module memory_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MemWrite_Enable,
    input  logic [7:0] Address,
    input  logic [7:0] WriteData,
    output logic [7:0] ReadData,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       uart_tx,
    output logic       timer_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;
    localparam logic [7:0] ADDR_TMR_CNT  = 8'hF2;
    localparam logic [7:0] ADDR_TMR_CMP  = 8'hF3;
    localparam logic [7:0] ADDR_TMR_CTRL = 8'hF4;
    localparam logic [7:0] ADDR_STATUS   = 8'hF5;
    localparam logic [7:0] ADDR_UART_TX  = 8'hF6;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // Storage and registers
    logic [7:0]       ram [0:239];
    logic [7:0]       gpio_sync1;
    logic [7:0]       gpio_sync2;
    logic [7:0]       tmr_cnt;
    logic [7:0]       tmr_cmp;
    logic [3:0]       tmr_ctrl;
    logic [6:0]       prescaler;
    logic             match;
    logic             ovf;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    uart_state_t      uart_state;
    uart_state_t      uart_state_next;
    logic [CLK_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       tx_shift;

    // Decoded strobes
    logic             wr_ram;
    logic             wr_gpio_out;
    logic             wr_tmr_cmp;
    logic             wr_tmr_ctrl;
    logic             wr_status;
    logic             wr_uart;
    logic [6:0]       ps_limit;
    logic             tmr_tick;
    logic             match_set;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_push;
    logic             fifo_drop;
    logic             bit_done;
    logic             tx_busy;

    // Write address decode
    always_comb begin
        wr_ram      = MemWrite_Enable && (Address < ADDR_GPIO_OUT);
        wr_gpio_out = MemWrite_Enable && (Address == ADDR_GPIO_OUT);
        wr_tmr_cmp  = MemWrite_Enable && (Address == ADDR_TMR_CMP);
        wr_tmr_ctrl = MemWrite_Enable && (Address == ADDR_TMR_CTRL);
        wr_status   = MemWrite_Enable && (Address == ADDR_STATUS);
        wr_uart     = MemWrite_Enable && (Address == ADDR_UART_TX);
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[Address] <= WriteData;
        end
    end

    // GPIO output register and two-flop input synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out   <= 8'h00;
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (wr_gpio_out) begin
                gpio_out <= WriteData;
            end
        end
    end

    // Prescaler terminal count 2^PS-1; PS=7 wraps 7'd1<<7 to 0, giving 127
    always_comb begin
        ps_limit  = (7'd1 << tmr_ctrl[3:1]) - 7'd1;
        tmr_tick  = tmr_ctrl[0] && (prescaler == ps_limit);
        match_set = tmr_tick && (tmr_cnt == tmr_cmp);
    end

    // Timer registers; a set of match beats a same-cycle W1C clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_cnt   <= 8'h00;
            tmr_cmp   <= 8'hFF;
            tmr_ctrl  <= 4'h0;
            prescaler <= 7'd0;
            match     <= 1'b0;
        end else begin
            if (wr_tmr_cmp) begin
                tmr_cmp <= WriteData;
            end
            if (wr_tmr_ctrl) begin
                tmr_ctrl <= WriteData[3:0];
            end
            if (!tmr_ctrl[0] || tmr_tick) begin
                prescaler <= 7'd0;
            end else begin
                prescaler <= prescaler + 7'd1;
            end
            if (tmr_tick) begin
                tmr_cnt <= match_set ? 8'h00 : tmr_cnt + 8'h01;
            end
            if (match_set) begin
                match <= 1'b1;
            end else if (wr_status && WriteData[0]) begin
                match <= 1'b0;
            end
        end
    end

    // FIFO flags; a full FIFO still accepts a push if it pops on the same edge
    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
        fifo_pop   = (uart_state == UART_IDLE) && !fifo_empty;
        fifo_push  = wr_uart && (!fifo_full || fifo_pop);
        fifo_drop  = wr_uart && fifo_full && !fifo_pop;
    end

    // FIFO data array; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= WriteData;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (fifo_drop) begin
                ovf <= 1'b1;
            end else if (wr_status && WriteData[4]) begin
                ovf <= 1'b0;
            end
        end
    end

    // UART state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_state <= UART_IDLE;
        end else begin
            uart_state <= uart_state_next;
        end
    end

    // UART next state and serial line; each non-idle state spans CLKS_PER_BIT clocks per bit
    always_comb begin
        uart_state_next = uart_state;
        uart_tx         = 1'b1;
        bit_done        = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
        case (uart_state)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    uart_state_next = UART_START;
                end
            end
            UART_START: begin
                uart_tx = 1'b0;
                if (bit_done) begin
                    uart_state_next = UART_DATA;
                end
            end
            UART_DATA: begin
                uart_tx = tx_shift[0];
                if (bit_done && (bit_idx == 3'd7)) begin
                    uart_state_next = UART_STOP;
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    uart_state_next = UART_IDLE;
                end
            end
            default: begin
                uart_state_next = UART_IDLE;
            end
        endcase
    end

    // UART datapath: bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt  <= '0;
            bit_idx  <= 3'd0;
            tx_shift <= 8'h00;
        end else begin
            if ((uart_state == UART_IDLE) || bit_done) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CLK_W'(1);
            end
            if (uart_state != UART_DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (fifo_pop) begin
                tx_shift <= fifo_mem[rd_ptr];
            end else if ((uart_state == UART_DATA) && bit_done) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
            end
        end
    end

    // Status outputs
    always_comb begin
        tx_busy   = (uart_state != UART_IDLE);
        timer_irq = match;
    end

    // Combinational read mux; unmapped and write-only locations read 0
    always_comb begin
        ReadData = 8'h00;
        if (Address < ADDR_GPIO_OUT) begin
            ReadData = ram[Address];
        end else begin
            case (Address)
                ADDR_GPIO_OUT: ReadData = gpio_out;
                ADDR_GPIO_IN:  ReadData = gpio_sync2;
                ADDR_TMR_CNT:  ReadData = tmr_cnt;
                ADDR_TMR_CMP:  ReadData = tmr_cmp;
                ADDR_TMR_CTRL: ReadData = {4'h0, tmr_ctrl};
                ADDR_STATUS:   ReadData = {3'b000, ovf, fifo_empty, fifo_full, tx_busy, match};
                default:       ReadData = 8'h00;
            endcase
        end
    end

endmodule
